// File: rtl/pipe_vector_packer.sv
// Packs a serial stream of Width-bit beats into an Elements-lane vector, lane 0 first.
// A fill register and an output register let streaming run at one beat per cycle.
module pipe_vector_packer #(
    parameter int unsigned Elements = 12,
    parameter int unsigned Width    = 8
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic [Width-1:0]                   s_data_in,
    input  logic                               s_valid_in,
    input  logic                               s_last_in,
    output logic                               s_ready_out,
    output logic [Elements-1:0][Width-1:0]     m_data_out,
    output logic [$clog2(Elements+1)-1:0]      m_count_out,
    output logic                               m_valid_out,
    input  logic                               m_ready_in
);

    localparam int unsigned IdxW = (Elements > 1) ? $clog2(Elements) : 1;
    localparam int unsigned CntW = $clog2(Elements + 1);

    logic [Elements-1:0][Width-1:0] fill_q, fill_d;
    logic [Elements-1:0][Width-1:0] out_q, out_d;
    logic [Elements-1:0][Width-1:0] comp_vec;
    logic [IdxW-1:0]                idx_q, idx_d;
    logic [CntW-1:0]                pend_cnt_q, pend_cnt_d;
    logic [CntW-1:0]                out_cnt_q, out_cnt_d;
    logic                           pend_q, pend_d;
    logic                           out_valid_q, out_valid_d;
    logic                           accept, complete, xfer, out_free;

    assign s_ready_out = ~pend_q;
    assign m_data_out  = out_q;
    assign m_count_out = out_cnt_q;
    assign m_valid_out = out_valid_q;

    assign accept   = s_valid_in & ~pend_q;
    assign complete = accept & ((Elements == 1) || s_last_in ||
                                (idx_q == IdxW'(Elements - 1)));
    assign xfer     = out_valid_q & m_ready_in;
    assign out_free = ~out_valid_q | xfer;

    // Completed vector: lanes below idx from the fill reg, the current beat, zeros above.
    always_comb begin
        comp_vec = '0;
        for (int i = 0; i < int'(Elements); i++) begin
            if (IdxW'(i) < idx_q) begin
                comp_vec[i] = fill_q[i];
            end else if (IdxW'(i) == idx_q) begin
                comp_vec[i] = s_data_in;
            end
        end
    end

    always_comb begin
        fill_d      = fill_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_cnt_d  = pend_cnt_q;
        out_d       = out_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q & ~xfer;
        if (pend_q) begin
            // Input is stalled; the held vector moves out as soon as the output drains.
            if (xfer) begin
                out_d       = fill_q;
                out_cnt_d   = pend_cnt_q;
                out_valid_d = 1'b1;
                pend_d      = 1'b0;
                fill_d      = '0;
            end
        end else if (accept) begin
            if (complete) begin
                idx_d = '0;
                if (out_free) begin
                    out_d       = comp_vec;
                    out_cnt_d   = CntW'(idx_q) + 1'b1;
                    out_valid_d = 1'b1;
                    fill_d      = '0;
                end else begin
                    fill_d     = comp_vec;
                    pend_cnt_d = CntW'(idx_q) + 1'b1;
                    pend_d     = 1'b1;
                end
            end else begin
                fill_d[idx_q] = s_data_in;
                idx_d         = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fill_q      <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            pend_cnt_q  <= '0;
            out_q       <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_cnt_q  <= pend_cnt_d;
            out_q       <= out_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_pipe_vector_packer.sv
// Directed and scoreboarded bench for pipe_vector_packer with 4-lane and 12-lane instances.
module tb_pipe_vector_packer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]      s_data4;
    logic            s_valid4, s_last4, s_ready4, m_valid4, m_ready4;
    logic [3:0][7:0] m_data4;
    logic [2:0]      m_count4;

    logic [7:0]       s_data12;
    logic             s_valid12, s_last12, s_ready12, m_valid12, m_ready12;
    logic [11:0][7:0] m_data12;
    logic [3:0]       m_count12;

    int errors = 0;
    int checks = 0;

    pipe_vector_packer #(.Elements(4), .Width(8)) dut4 (
        .clk_in(clk), .rst_n_in(rst_n),
        .s_data_in(s_data4), .s_valid_in(s_valid4), .s_last_in(s_last4),
        .s_ready_out(s_ready4), .m_data_out(m_data4), .m_count_out(m_count4),
        .m_valid_out(m_valid4), .m_ready_in(m_ready4)
    );

    pipe_vector_packer #(.Elements(12), .Width(8)) dut12 (
        .clk_in(clk), .rst_n_in(rst_n),
        .s_data_in(s_data12), .s_valid_in(s_valid12), .s_last_in(s_last12),
        .s_ready_out(s_ready12), .m_data_out(m_data12), .m_count_out(m_count12),
        .m_valid_out(m_valid12), .m_ready_in(m_ready12)
    );

    // Drive the 4-lane instance for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick4(input logic v, input logic [7:0] d, input logic l, input logic r);
        s_valid4 = v; s_data4 = d; s_last4 = l; m_ready4 = r;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        s_valid4 = 0; s_data4 = 0; s_last4 = 0; m_ready4 = 0;
        s_valid12 = 0; s_data12 = 0; s_last12 = 0; m_ready12 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (m_valid4 !== 1'b0 || m_data4 !== 32'h0 || m_count4 !== 3'd0 || s_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL reset4: valid=%b data=%h count=%0d ready=%b, want 0 0 0 1",
                     m_valid4, m_data4, m_count4, s_ready4);
        end
        checks++;
        if (m_valid12 !== 1'b0 || m_data12 !== 96'h0 || m_count12 !== 4'd0 || s_ready12 !== 1'b1) begin
            errors++;
            $display("FAIL reset12: valid=%b count=%0d ready=%b, want 0 0 1",
                     m_valid12, m_count12, s_ready12);
        end
    endtask

    task automatic test_full_vector();
        tick4(1, 8'd1, 0, 1);
        tick4(1, 8'd2, 0, 1);
        tick4(1, 8'd3, 0, 1);
        checks++;
        if (m_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL full_early_valid: valid=%b, want 0", m_valid4);
        end
        tick4(1, 8'd4, 0, 1);
        checks++;
        if (m_valid4 !== 1'b1 || m_data4 !== 32'h04030201 || m_count4 !== 3'd4) begin
            errors++;
            $display("FAIL full_vector: valid=%b data=%h count=%0d, want 1 04030201 4",
                     m_valid4, m_data4, m_count4);
        end
        tick4(0, 8'd0, 0, 1);
        checks++;
        if (m_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL full_one_cycle: valid=%b, want 0", m_valid4);
        end
    endtask

    task automatic test_partial();
        tick4(1, 8'd5, 0, 1);
        tick4(1, 8'd6, 1, 1);
        checks++;
        if (m_valid4 !== 1'b1 || m_data4 !== 32'h00000605 || m_count4 !== 3'd2) begin
            errors++;
            $display("FAIL partial: valid=%b data=%h count=%0d, want 1 00000605 2",
                     m_valid4, m_data4, m_count4);
        end
        // s_last with no valid beat must not create a vector
        tick4(0, 8'd0, 1, 1);
        tick4(1, 8'd7, 0, 1);
        tick4(1, 8'd8, 0, 1);
        tick4(1, 8'd9, 0, 1);
        checks++;
        if (m_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL idle_last: valid=%b, want 0", m_valid4);
        end
        tick4(1, 8'd10, 1, 1);
        checks++;
        if (m_valid4 !== 1'b1 || m_data4 !== 32'h0a090807 || m_count4 !== 3'd4) begin
            errors++;
            $display("FAIL after_partial: valid=%b data=%h count=%0d, want 1 0a090807 4",
                     m_valid4, m_data4, m_count4);
        end
        tick4(0, 8'd0, 0, 1);
    endtask

    task automatic test_stall();
        int acc = 0;
        for (int i = 0; i < 12; i++) begin
            logic rdy;
            rdy = s_ready4;
            tick4(1, 8'h20 + 8'(acc), 0, 0);
            if (rdy) acc++;
        end
        checks++;
        if (acc !== 8 || s_ready4 !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept: accepted=%0d ready=%b, want 8 0", acc, s_ready4);
        end
        for (int i = 0; i < 3; i++) begin
            tick4(0, 8'd0, 0, 0);
            checks++;
            if (m_valid4 !== 1'b1 || m_data4 !== 32'h23222120 || m_count4 !== 3'd4) begin
                errors++;
                $display("FAIL stall_hold: valid=%b data=%h count=%0d, want 1 23222120 4",
                         m_valid4, m_data4, m_count4);
            end
        end
        tick4(0, 8'd0, 0, 1);
        checks++;
        if (m_valid4 !== 1'b1 || m_data4 !== 32'h27262524 || s_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL stall_drain2: valid=%b data=%h ready=%b, want 1 27262524 1",
                     m_valid4, m_data4, s_ready4);
        end
        tick4(0, 8'd0, 0, 1);
        checks++;
        if (m_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL stall_empty: valid=%b, want 0", m_valid4);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]       beats [120];
        logic [11:0][7:0] expv;
        int nv = 0, low = 0, last_cyc = 0;
        for (int c = 0; c < 121; c++) begin
            if (c < 120) begin
                beats[c] = 8'($urandom);
                s_valid12 = 1; s_data12 = beats[c];
                if (!s_ready12) low++;
            end else begin
                s_valid12 = 0;
            end
            s_last12 = 0; m_ready12 = 1;
            @(posedge clk); #1;
            if (m_valid12) begin
                for (int k = 0; k < 12; k++) expv[k] = beats[nv * 12 + k];
                checks++;
                if (m_data12 !== expv || m_count12 !== 4'd12) begin
                    errors++;
                    $display("FAIL b2b_vec%0d: data=%h count=%0d, want %h 12",
                             nv, m_data12, m_count12, expv);
                end
                if (nv > 0) begin
                    checks++;
                    if (c - last_cyc != 12) begin
                        errors++;
                        $display("FAIL b2b_gap: spacing=%0d, want 12", c - last_cyc);
                    end
                end
                last_cyc = c;
                nv++;
            end
            if (nv > 10) break;
        end
        s_valid12 = 0;
        checks++;
        if (nv != 10 || low != 0) begin
            errors++;
            $display("FAIL b2b_total: vectors=%0d ready_low=%0d, want 10 0", nv, low);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) tick4(1, 8'h40 + 8'(i), 0, 0);
        checks++;
        if (s_ready4 !== 1'b0 || m_valid4 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pending: ready=%b valid=%b, want 0 1", s_ready4, m_valid4);
        end
        apply_reset();
        checks++;
        if (m_valid4 !== 1'b0 || m_data4 !== 32'h0 || m_count4 !== 3'd0 || s_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_pending: valid=%b data=%h count=%0d ready=%b, want 0 0 0 1",
                     m_valid4, m_data4, m_count4, s_ready4);
        end
        for (int i = 0; i < 6; i++) tick4(1, 8'h50 + 8'(i), 0, 0);
        apply_reset();
        checks++;
        if (m_valid4 !== 1'b0 || m_data4 !== 32'h0 || s_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_partial: valid=%b data=%h ready=%b, want 0 0 1",
                     m_valid4, m_data4, s_ready4);
        end
        tick4(1, 8'h61, 0, 1);
        tick4(1, 8'h62, 0, 1);
        tick4(1, 8'h63, 0, 1);
        tick4(1, 8'h64, 0, 1);
        checks++;
        if (m_valid4 !== 1'b1 || m_data4 !== 32'h64636261 || m_count4 !== 3'd4) begin
            errors++;
            $display("FAIL post_reset_vec: valid=%b data=%h count=%0d, want 1 64636261 4",
                     m_valid4, m_data4, m_count4);
        end
        tick4(0, 8'd0, 0, 1);
    endtask

    task automatic test_random_scoreboard();
        logic [31:0]     q_data [$];
        logic [2:0]      q_cnt  [$];
        logic [3:0][7:0] mv, hold;
        logic [2:0]      holdc;
        logic            v, l, r, stalled;
        logic [7:0]      d;
        int midx = 0, acc = 0, cyc = 0, nvec = 0;
        mv = '0; hold = '0; holdc = '0; stalled = 0;
        while ((acc < 2000 || q_data.size() > 0 || m_valid4) && cyc < 20000) begin
            if (acc < 2000) begin
                v = ($urandom_range(0, 3) != 0);
                d = 8'($urandom);
                l = ($urandom_range(0, 4) == 0) || (acc == 1999);
                r = 1'($urandom_range(0, 1));
            end else begin
                v = 0; d = 0; l = 0; r = 1;
            end
            s_valid4 = v; s_data4 = d; s_last4 = l; m_ready4 = r;
            if (v && s_ready4) begin
                mv[midx] = d;
                if (midx == 3 || l) begin
                    for (int k = midx + 1; k < 4; k++) mv[k] = 8'h0;
                    q_data.push_back(mv);
                    q_cnt.push_back(3'(midx + 1));
                    mv = '0;
                    midx = 0;
                end else begin
                    midx++;
                end
                acc++;
            end
            if (m_valid4 && r) begin
                checks++;
                if (q_data.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: data=%h count=%0d, want no vector", m_data4, m_count4);
                end else begin
                    if (m_data4 !== q_data[0] || m_count4 !== q_cnt[0]) begin
                        errors++;
                        $display("FAIL sb_vec%0d: data=%h count=%0d, want %h %0d",
                                 nvec, m_data4, m_count4, q_data[0], q_cnt[0]);
                    end
                    void'(q_data.pop_front());
                    void'(q_cnt.pop_front());
                end
                nvec++;
            end
            stalled = m_valid4 && !r;
            hold = m_data4; holdc = m_count4;
            @(posedge clk); #1;
            cyc++;
            if (stalled) begin
                checks++;
                if (m_valid4 !== 1'b1 || m_data4 !== hold || m_count4 !== holdc) begin
                    errors++;
                    $display("FAIL sb_stable: valid=%b data=%h count=%0d, want 1 %h %0d",
                             m_valid4, m_data4, m_count4, hold, holdc);
                end
            end
        end
        checks++;
        if (cyc >= 20000 || q_data.size() != 0 || acc != 2000) begin
            errors++;
            $display("FAIL sb_drain: cycles=%0d left=%0d accepted=%0d, want <20000 0 2000",
                     cyc, q_data.size(), acc);
        end
        s_valid4 = 0; s_last4 = 0;
    endtask

    initial begin
        test_reset();
        test_full_vector();
        test_partial();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random_scoreboard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
